programmable_delay_line: RTL and testbench

PROGRAMMABLE_DELAY_LINE -- requirements
Module: programmable_delay_line

---
 rtl/programmable_delay_line_pkg.sv | 21 ++
 rtl/pdl_ring_buffer.sv | 66 ++++++
 rtl/programmable_delay_line.sv | 133 +++++++++++++
 tb/tb_programmable_delay_line.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/programmable_delay_line_pkg.sv
// ---------------------------------------------------------------------------
// programmable_delay_line_pkg : shared FSM encoding and width helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package programmable_delay_line_pkg;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } pdl_state_e;

   // Width of a field able to hold every value 0..max_delay.
   function automatic int dly_width(input int max_delay);
      return $clog2(max_delay + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pdl_ring_buffer.sv
// ---------------------------------------------------------------------------
// pdl_ring_buffer : circular storage with write and read pointers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdl_ring_buffer #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_rd_adv,
   input  logic             i_rd_rebase,
   output logic [WIDTH-1:0] o_rd_data
);

   localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] STEP = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    rd_ptr_d;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST) ? '0 : p + STEP;
   endfunction

   always_comb begin
      wr_ptr_d = i_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_rd_rebase) begin
         rd_ptr_d = wr_ptr_q;
      end else if (i_rd_adv) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   // Look-ahead read of the slot the read pointer lands on; a slot being
   // written on this same edge is forwarded straight from the input.
   assign o_rd_data = (i_push && (rd_ptr_d == wr_ptr_q)) ? i_wdata : mem_q[rd_ptr_d];

   always_ff @(posedge clk) begin
      if (i_push) begin
         mem_q[wr_ptr_q] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/programmable_delay_line.sv
// ---------------------------------------------------------------------------
// programmable_delay_line : enable-clocked delay line with runtime delay load
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module programmable_delay_line
   import programmable_delay_line_pkg::*;
#(
   parameter  int DATA_WIDTH  = 32,
   parameter  int MAX_DELAY   = 32,
   parameter  int RESET_DELAY = 32,
   localparam int DLY_W       = dly_width(MAX_DELAY)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_delay_load,
   input  logic [DLY_W-1:0]      i_delay,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_filling,
   output logic [DLY_W-1:0]      o_delay,
   output logic                  o_err
);

   localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);
   localparam logic [DLY_W-1:0] RST_D = DLY_W'(RESET_DELAY);
   localparam logic [DLY_W-1:0] ONE   = DLY_W'(1);
   localparam int               RW    = DATA_WIDTH + 1;

   pdl_state_e            state_q;
   pdl_state_e            state_d;
   logic [DLY_W-1:0]      cnt_q;
   logic [DLY_W-1:0]      cnt_d;
   logic [DLY_W-1:0]      cnt_inc;
   logic [DLY_W-1:0]      delay_q;
   logic [DLY_W-1:0]      delay_d;
   logic                  err_q;
   logic                  err_d;
   logic                  vld_q;
   logic                  vld_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] data_d;
   logic                  load_ok;
   logic                  rd_adv;
   logic                  rd_rebase;
   logic [RW-1:0]         rd_word;

   assign load_ok = i_delay_load && (i_delay != '0) && (i_delay <= MAX_D);
   assign cnt_inc = cnt_q + ONE;

   pdl_ring_buffer #(
      .WIDTH (RW),
      .DEPTH (MAX_DELAY)
   ) u_ring (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (i_en & rst_n),
      .i_wdata     ({i_valid, i_data}),
      .i_rd_adv    (rd_adv),
      .i_rd_rebase (rd_rebase),
      .o_rd_data   (rd_word)
   );

   // The read pointer parks on the first fill sample while filling and only
   // starts trailing the writer once the line is full.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      delay_d   = delay_q;
      err_d     = err_q | (i_delay_load & ~load_ok);
      data_d    = data_q;
      vld_d     = vld_q;
      rd_adv    = 1'b0;
      rd_rebase = 1'b0;

      if (load_ok) begin
         delay_d   = i_delay;
         rd_rebase = 1'b1;
         state_d   = ST_FILL;
         cnt_d     = '0;
         if (i_en) begin
            cnt_d = ONE;
            if (i_delay == ONE) begin
               state_d = ST_RUN;
            end
         end
      end else if (i_en) begin
         if (state_q == ST_FILL) begin
            cnt_d = cnt_inc;
            if (cnt_inc == delay_q) begin
               state_d = ST_RUN;
            end
         end else begin
            rd_adv = 1'b1;
         end
      end

      if (i_en) begin
         {vld_d, data_d} = rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_FILL;
         cnt_q   <= '0;
         delay_q <= RST_D;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         delay_q <= delay_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
      end
   end

   assign o_data    = data_q;
   assign o_valid   = vld_q & (state_q == ST_RUN);
   assign o_filling = (state_q == ST_FILL);
   assign o_delay   = delay_q;
   assign o_err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_programmable_delay_line.sv
// ---------------------------------------------------------------------------
// tb_programmable_delay_line : directed self-checking bench
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_programmable_delay_line;

   localparam int DW   = 32;
   localparam int MAXD = 32;
   localparam int RSTD = 32;
   localparam int DLYW = 6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            i_en;
   logic            i_valid;
   logic [DW-1:0]   i_data;
   logic            i_delay_load;
   logic [DLYW-1:0] i_delay;
   logic [DW-1:0]   o_data;
   logic            o_valid;
   logic            o_filling;
   logic [DLYW-1:0] o_delay;
   logic            o_err;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   seq;
   int   base;
   int   jj;
   int   cur_d;
   logic exp_err;

   always #5 clk = ~clk;

   programmable_delay_line #(
      .DATA_WIDTH  (DW),
      .MAX_DELAY   (MAXD),
      .RESET_DELAY (RSTD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_en         (i_en),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .i_delay_load (i_delay_load),
      .i_delay      (i_delay),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_filling    (o_filling),
      .o_delay      (o_delay),
      .o_err        (o_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Qualifier pattern of sample s: all valid early on, then every fifth dropped.
   function automatic logic vld_of(input int s);
      return (s <= 40) || ((s % 5) != 0);
   endfunction

   task automatic do_reset();
      rst_n        = 1'b0;
      i_en         = 1'b1;
      i_valid      = 1'b1;
      i_delay_load = 1'b1;
      i_delay      = 6'd5;
      i_data       = 32'hdead_beef;
      tick();
      rst_n        = 1'b1;
      i_en         = 1'b0;
      i_delay_load = 1'b0;
      check("rst_data", o_data, 0);
      check("rst_valid", o_valid, 0);
      check("rst_filling", o_filling, 1);
      check("rst_delay", o_delay, RSTD);
      check("rst_err", o_err, 0);
      cur_d   = RSTD;
      base    = seq;
      jj      = 0;
      exp_err = 1'b0;
   endtask

   task automatic adv(input logic ld, input int d);
      i_delay_load = ld;
      i_delay      = d[DLYW-1:0];
      i_en         = 1'b1;
      i_valid      = vld_of(seq);
      i_data       = seq;
      tick();
      i_delay_load = 1'b0;
      if (ld) begin
         if (d >= 1 && d <= MAXD) begin
            cur_d = d;
            base  = seq;
            jj    = 0;
         end else begin
            exp_err = 1'b1;
         end
      end
      seq++;
      jj++;
      check("delay", o_delay, cur_d);
      check("err", o_err, exp_err);
      if (jj < cur_d) begin
         check("filling", o_filling, 1);
         check("valid_fill", o_valid, 0);
      end else begin
         check("filling_run", o_filling, 0);
         check("valid_run", o_valid, vld_of(base + jj - cur_d));
         check("data", o_data, base + jj - cur_d);
      end
   endtask

   task automatic stall(input int n);
      i_en    = 1'b0;
      i_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         i_data = $urandom;
         tick();
         check("stall_data", o_data, base + jj - cur_d);
         check("stall_valid", o_valid, vld_of(base + jj - cur_d));
      end
   endtask

   task automatic load_idle(input int d);
      i_en         = 1'b0;
      i_delay_load = 1'b1;
      i_delay      = d[DLYW-1:0];
      tick();
      i_delay_load = 1'b0;
      cur_d = d;
      base  = seq;
      jj    = 0;
      check("idle_load_delay", o_delay, d);
      check("idle_load_filling", o_filling, 1);
      check("idle_load_valid", o_valid, 0);
   endtask

   initial begin
      rst_n        = 1'b0;
      i_en         = 1'b0;
      i_valid      = 1'b0;
      i_data       = '0;
      i_delay_load = 1'b0;
      i_delay      = '0;
      seq          = 1;
      exp_err      = 1'b0;
      cur_d        = RSTD;
      base         = 1;
      jj           = 0;

      // Reset delay: first valid output on enabled edge 32 carrying sample 1.
      do_reset();
      repeat (40) adv(1'b0, 0);

      // Stall at D=4.
      adv(1'b1, 4);
      repeat (11) adv(1'b0, 0);
      stall(10);
      repeat (6) adv(1'b0, 0);

      // Runtime change 8 -> 3 together with an enabled sample.
      adv(1'b1, 8);
      repeat (15) adv(1'b0, 0);
      adv(1'b1, 3);
      repeat (6) adv(1'b0, 0);

      // Reload while still filling.
      adv(1'b1, 8);
      repeat (3) adv(1'b0, 0);
      adv(1'b1, 5);
      repeat (8) adv(1'b0, 0);

      // Illegal loads leave the line running at D=5.
      adv(1'b1, 0);
      adv(1'b0, 0);
      adv(1'b1, MAXD + 1);
      repeat (4) adv(1'b0, 0);

      // Load without an enabled sample.
      load_idle(6);
      repeat (10) adv(1'b0, 0);

      // Pointer wrap at both extremes.
      adv(1'b1, MAXD);
      repeat (3 * MAXD - 1) adv(1'b0, 0);
      adv(1'b1, 1);
      repeat (3 * MAXD - 1) adv(1'b0, 0);

      // Reset in the middle of a fill, then refill at the reset delay.
      adv(1'b1, 20);
      repeat (7) adv(1'b0, 0);
      do_reset();
      repeat (RSTD + 3) adv(1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
